// File: rtl/band_meter.sv
// Spectrum display meter: once per accepted frame, snapshots seven band magnitudes
// and sweeps them one per cycle into ballistic level / peak-hold registers.
module band_meter #(
  parameter int unsigned DECAY_STEP  = 4,
  parameter int unsigned PEAK_FALL   = 2,
  parameter int unsigned HOLD_FRAMES = 30,
  parameter int unsigned CLIP_FRAMES = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       freeze,
  input  logic [7:0] freq1,
  input  logic [7:0] freq2,
  input  logic [7:0] freq3,
  input  logic [7:0] freq4,
  input  logic [7:0] freq5,
  input  logic [7:0] freq6,
  input  logic [7:0] freq7,
  input  logic [2:0] rd_band,
  output logic [7:0] rd_level,
  output logic [7:0] rd_peak,
  output logic       busy,
  output logic       clip,
  output logic       overrun
);

  localparam int          NBANDS  = 7;
  localparam logic [7:0]  DECAY_B = 8'(DECAY_STEP);
  localparam logic [7:0]  FALL_B  = 8'(PEAK_FALL);
  localparam logic [7:0]  HOLD_B  = 8'(HOLD_FRAMES);
  localparam logic [7:0]  CLIP_B  = 8'(CLIP_FRAMES);
  localparam logic [2:0]  LAST_IDX = 3'(NBANDS - 1);

  typedef enum logic [0:0] {IDLE, SWEEP} state_t;

  state_t     state_reg, state_next;
  logic [2:0] idx_reg, idx_next;
  logic       accept, upd;

  logic [7:0] freq_in   [0:NBANDS-1];
  logic [7:0] snap_reg  [0:NBANDS-1];
  logic [7:0] level_reg [0:NBANDS-1];
  logic [7:0] peak_reg  [0:NBANDS-1];
  logic [7:0] hold_reg  [0:NBANDS-1];
  logic [NBANDS-1:0] hit;

  logic [7:0] clip_cnt_reg, clip_cnt_next;
  logic       busy_reg, clip_reg, overrun_reg;
  logic [7:0] rd_level_reg, rd_peak_reg;

  assign freq_in[0] = freq1;
  assign freq_in[1] = freq2;
  assign freq_in[2] = freq3;
  assign freq_in[3] = freq4;
  assign freq_in[4] = freq5;
  assign freq_in[5] = freq6;
  assign freq_in[6] = freq7;

  // Clip is judged on the live inputs at the accepting edge, i.e. the snapshot bytes.
  genvar gi;
  generate
    for (gi = 0; gi < NBANDS; gi++) begin : g_hit
      assign hit[gi] = (freq_in[gi] == 8'hFF);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    accept     = 1'b0;
    upd        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (frame_tick && !freeze) begin
          accept     = 1'b1;
          state_next = SWEEP;
          idx_next   = 3'd0;
        end
      end
      SWEEP: begin
        upd = 1'b1;
        if (idx_reg == LAST_IDX) begin
          state_next = IDLE;
          idx_next   = 3'd0;
        end else begin
          idx_next = idx_reg + 3'd1;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = 3'd0;
      end
    endcase
  end

  // One shared update datapath, steered by the sweep index.
  logic [7:0] cur_s, cur_l, cur_p, cur_h;
  logic [7:0] level_dec, level_new, peak_fall, peak_new, hold_new;

  always_comb begin
    cur_s = snap_reg[idx_reg];
    cur_l = level_reg[idx_reg];
    cur_p = peak_reg[idx_reg];
    cur_h = hold_reg[idx_reg];

    level_dec = (cur_l > DECAY_B) ? (cur_l - DECAY_B) : 8'd0;
    level_new = (cur_s > cur_l) ? cur_s : level_dec;

    peak_fall = (cur_p > FALL_B) ? (cur_p - FALL_B) : 8'd0;
    peak_new  = cur_p;
    hold_new  = cur_h;
    if (cur_s >= cur_p) begin
      peak_new = cur_s;
      hold_new = HOLD_B;
    end else if (cur_h != 8'd0) begin
      hold_new = cur_h - 8'd1;
    end else begin
      // Falling peak never drops under the freshly computed level.
      peak_new = (peak_fall > level_new) ? peak_fall : level_new;
    end
  end

  always_comb begin
    clip_cnt_next = clip_cnt_reg;
    if (accept) begin
      if (|hit)
        clip_cnt_next = CLIP_B;
      else if (clip_cnt_reg != 8'd0)
        clip_cnt_next = clip_cnt_reg - 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      idx_reg      <= 3'd0;
      busy_reg     <= 1'b0;
      clip_cnt_reg <= 8'd0;
      clip_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
      rd_level_reg <= 8'd0;
      rd_peak_reg  <= 8'd0;
      for (int i = 0; i < NBANDS; i++) begin
        snap_reg[i]  <= 8'd0;
        level_reg[i] <= 8'd0;
        peak_reg[i]  <= 8'd0;
        hold_reg[i]  <= 8'd0;
      end
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      busy_reg     <= (state_next == SWEEP);
      clip_cnt_reg <= clip_cnt_next;
      clip_reg     <= (clip_cnt_next != 8'd0);
      if (state_reg == SWEEP && frame_tick && !freeze)
        overrun_reg <= 1'b1;

      // Read samples the arrays before this edge's update lands.
      if (rd_band <= LAST_IDX) begin
        rd_level_reg <= level_reg[rd_band];
        rd_peak_reg  <= peak_reg[rd_band];
      end else begin
        rd_level_reg <= 8'd0;
        rd_peak_reg  <= 8'd0;
      end

      for (int i = 0; i < NBANDS; i++) begin
        if (accept)
          snap_reg[i] <= freq_in[i];
        if (upd && idx_reg == 3'(i)) begin
          level_reg[i] <= level_new;
          peak_reg[i]  <= peak_new;
          hold_reg[i]  <= hold_new;
        end
      end
    end
  end

  assign busy     = busy_reg;
  assign clip     = clip_reg;
  assign overrun  = overrun_reg;
  assign rd_level = rd_level_reg;
  assign rd_peak  = rd_peak_reg;

endmodule

// File: tb/tb_band_meter.sv
// Self-checking bench for band_meter: reference model plus read scoreboard.
module tb_band_meter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       freeze = 1'b0;
  logic [7:0] freq [0:6];
  logic [2:0] rd_band = 3'd0;
  logic [7:0] rd_level, rd_peak;
  logic       busy, clip, overrun;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [2:0] band;
    logic [7:0] lvl;
    logic [7:0] pk;
  } exp_t;
  exp_t sb[$];

  int m_level [0:6];
  int m_peak  [0:6];
  int m_hold  [0:6];
  int m_clip;
  int last_lvl, last_pk;

  band_meter dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .freeze(freeze),
    .freq1(freq[0]), .freq2(freq[1]), .freq3(freq[2]), .freq4(freq[3]),
    .freq5(freq[4]), .freq6(freq[5]), .freq7(freq[6]),
    .rd_band(rd_band), .rd_level(rd_level), .rd_peak(rd_peak),
    .busy(busy), .clip(clip), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 7; i++) begin
      m_level[i] = 0; m_peak[i] = 0; m_hold[i] = 0;
    end
    m_clip = 0;
  endtask

  task automatic model_frame();
    bit any255 = 0;
    for (int i = 0; i < 7; i++) begin
      int s = freq[i];
      int l = m_level[i];
      int p = m_peak[i];
      int ln, pf;
      if (s == 255) any255 = 1;
      ln = (s > l) ? s : ((l > 4) ? l - 4 : 0);
      if (s >= p) begin
        m_peak[i] = s; m_hold[i] = 30;
      end else if (m_hold[i] != 0) begin
        m_hold[i]--;
      end else begin
        pf = (p > 2) ? p - 2 : 0;
        m_peak[i] = (pf > ln) ? pf : ln;
      end
      m_level[i] = ln;
    end
    if (any255) m_clip = 60;
    else if (m_clip != 0) m_clip--;
  endtask

  // Accepted frame: tick, model update, busy length check.
  task automatic do_frame(input string tag);
    int n = 0;
    frame_tick = 1'b1;
    model_frame();
    @(posedge clock); #1;
    frame_tick = 1'b0;
    while (busy && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk({tag, "_busy_cycles"}, n, 7);
    chk({tag, "_clip"}, clip, (m_clip != 0));
  endtask

  task automatic read_band(input int b);
    exp_t e, g;
    rd_band = 3'(b);
    e.band = 3'(b);
    e.lvl  = (b == 7) ? 8'd0 : 8'(m_level[b]);
    e.pk   = (b == 7) ? 8'd0 : 8'(m_peak[b]);
    sb.push_back(e);
    @(posedge clock); #1;
    g = sb.pop_front();
    last_lvl = rd_level;
    last_pk  = rd_peak;
    chk($sformatf("lvl_b%0d", g.band), rd_level, g.lvl);
    chk($sformatf("pk_b%0d", g.band), rd_peak, g.pk);
    $display("read band=%0d level=%0d peak=%0d", b, rd_level, rd_peak);
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < 7; i++) freq[i] = 8'(v);
  endtask

  initial begin
    int n;
    set_all(0);
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_clip", clip, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_rd_level", rd_level, 0);
    chk("rst_rd_peak", rd_peak, 0);
    #3 reset = 1'b1;
    @(posedge clock); #1;
    for (int b = 0; b < 8; b++) read_band(b);

    do_frame("first");

    // Attack then decay / hold / release on band 3
    freq[3] = 8'd200;
    do_frame("attack");
    read_band(3);
    chk("attack_lvl", last_lvl, 200);
    chk("attack_pk", last_pk, 200);
    freq[3] = 8'd0;
    for (int k = 1; k <= 130; k++) begin
      do_frame($sformatf("decay%0d", k));
      read_band(3);
      chk($sformatf("pk_ge_lvl%0d", k), (last_pk >= last_lvl), 1);
      if (k == 5)   begin chk("f5_lvl", last_lvl, 180); chk("f5_pk", last_pk, 200); end
      if (k == 30)  chk("f30_pk", last_pk, 200);
      if (k == 31)  begin chk("f31_lvl", last_lvl, 76); chk("f31_pk", last_pk, 198); end
      if (k == 50)  begin chk("f50_lvl", last_lvl, 0); chk("f50_pk", last_pk, 160); end
      if (k == 129) chk("f129_pk", last_pk, 2);
      if (k == 130) chk("f130_pk", last_pk, 0);
    end

    // Clip hold
    freq[6] = 8'd255;
    do_frame("clipset");
    chk("clip_set", clip, 1);
    freq[6] = 8'd0;
    for (int j = 1; j <= 60; j++) begin
      do_frame($sformatf("clip%0d", j));
      chk($sformatf("clip_after%0d", j), clip, (j < 60));
    end
    read_band(6);

    // Overrun: extra tick on sweep cycle 3 is dropped
    set_all(40);
    frame_tick = 1'b1;
    model_frame();
    @(posedge clock); #1;
    frame_tick = 1'b0;
    n = 1;
    @(posedge clock); #1; n++;
    frame_tick = 1'b1;
    @(posedge clock); #1;
    frame_tick = 1'b0;
    while (busy && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk("ovr_busy_cycles", n, 7);
    chk("ovr_flag", overrun, 1);
    repeat (10) @(posedge clock);
    #1;
    chk("ovr_no_extra_sweep", busy, 0);
    chk("ovr_sticky", overrun, 1);
    read_band(0);
    set_all(0);
    do_frame("post_ovr");
    chk("ovr_sticky2", overrun, 1);
    read_band(0);

    // Freeze: tick ignored
    set_all(90);
    freeze = 1'b1;
    frame_tick = 1'b1;
    @(posedge clock); #1;
    frame_tick = 1'b0;
    chk("frz_busy", busy, 0);
    @(posedge clock); #1;
    chk("frz_busy2", busy, 0);
    freeze = 1'b0;
    for (int b = 0; b < 7; b++) read_band(b);

    // Reset mid-sweep
    set_all(50);
    do_frame("pre_rst");
    set_all(100);
    freq[6] = 8'd255;
    rd_band = 3'd3;
    frame_tick = 1'b1;
    @(posedge clock); #1;
    frame_tick = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    chk("pre_rst_rd_level", rd_level, 50);
    chk("pre_rst_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_level", rd_level, 0);
    chk("mid_rst_rd_peak", rd_peak, 0);
    chk("mid_rst_clip", clip, 0);
    chk("mid_rst_overrun", overrun, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    for (int b = 0; b < 8; b++) read_band(b);
    set_all(70);
    do_frame("post_rst");
    for (int b = 0; b < 7; b++) read_band(b);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
